car_exit: RTL and testbench
===========================

// Module: car_exit
// PURPOSE
//  Exit-side counterpart of the garage parking mover: accepts a retrieval request for slot A/B/C, drives the
//  carrier gate->slot->gate via move_direction, and pulses a per-slot clear so occupancy logic frees the slot.
//  Sits beside the parking mover and consumes its A_full/B_full/C_full flags; shares the carrier direction bus encoding.
// PARAMETERS
//  STEP_CYCLES  4   clock cycles per carrier step (>=1)
//  A_DIST       1   steps from gate to slot A (1..7)
//  B_DIST       2   steps from gate to slot B (1..7)
//  C_DIST       3   steps from gate to slot C (1..7)
// PORTS
//  clk             in   1  system clock, rising edge
//  rst             in   1  synchronous reset, active-high
//  exit_req        in   1  retrieval request, sampled when idle
//  exit_place      in   2  01=A 10=B 11=C 00=invalid
//  A_full          in   1  slot A occupied
//  B_full          in   1  slot B occupied
//  C_full          in   1  slot C occupied
//  move_direction  out  3  000 stop, 001 forward (toward slots), 010 backward (toward gate), 100 grab
//  busy            out  1  high from accepted request through DONE cycle
//  clear_A         out  1  1-cycle pulse: slot A vacated
//  clear_B         out  1  1-cycle pulse: slot B vacated
//  clear_C         out  1  1-cycle pulse: slot C vacated
//  exit_done       out  1  1-cycle pulse: car delivered to gate
//  reject          out  1  1-cycle pulse: request refused
// BEHAVIOUR
//  Reset: state IDLE, counters 0, all outputs 0 (move_direction=000). Reset mid-operation aborts immediately, no clear/done pulse.
//  States: IDLE -> FWD -> GRAB -> BACK -> DONE -> IDLE. All outputs registered.
//  IDLE: on exit_req=1 at edge N:
//   - place valid and its _full=1: latch place and dist, enter FWD at N+1; busy=1, move_direction=001 from N+1.
//   - place 00 or target slot empty: reject=1 for cycle N+1, stay IDLE.
//  FWD: move_direction=001 for dist*STEP_CYCLES cycles, then GRAB.
//  GRAB: move_direction=100 for STEP_CYCLES cycles, then BACK.
//  BACK: move_direction=010 for dist*STEP_CYCLES cycles, then DONE.
//  DONE: one cycle; move_direction=000, exit_done=1, clear_<latched slot>=1, busy=1; next cycle IDLE, busy=0.
//  Total busy cycles = (2*dist+1)*STEP_CYCLES + 1.
//  Counters: cyc_cnt counts 0..STEP_CYCLES-1 and wraps, advancing step_cnt; step_cnt compared to latched dist (3 bits).
//  exit_req while busy: ignored, no reject, not queued.
//  _full inputs checked only at acceptance; later changes do not abort or alter sequence.
//  At most one of clear_A/B/C high at any time; clear and exit_done always coincide.
//  Request on the cycle DONE returns to IDLE: sampled only once state is IDLE (next edge).
// TESTING
//  STEP_CYCLES=4; req A (01), A_full=1 -> 001 x4, 100 x4, 010 x4, then exit_done+clear_A in cycle 13 after acceptance, busy 13 cycles.
//  req C (11), C_full=1 -> 001 x12, 100 x4, 010 x12, clear_C pulse in cycle 29; clear_A/B stay 0.
//  req B with B_full=0 -> reject pulse 1 cycle, busy=0, move_direction=000; req place 00 -> reject.
//  req A accepted, second exit_req (C) during FWD -> ignored, no reject, only clear_A at end.
//  rst=1 during GRAB of B -> next cycle all outputs 0, state IDLE, no clear_B; new req B accepted normally.
//  A_full drops to 0 during BACK of A run -> sequence completes, clear_A still pulses.

Source files
------------

// File: rtl/car_exit.sv
`default_nettype none
// ============================================================================
//  Module   : car_exit
//  Purpose  : Exit-side carrier sequencer. Moves the carrier gate -> slot ->
//             gate for a retrieval request and pulses the vacated slot's clear.
//  Revision : 1.0 - initial release
// ============================================================================
module car_exit #(
    parameter int STEP_CYCLES = 4,
    parameter int A_DIST      = 1,
    parameter int B_DIST      = 2,
    parameter int C_DIST      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exit_req,
    input  logic [1:0] exit_place,
    input  logic       A_full,
    input  logic       B_full,
    input  logic       C_full,
    output logic [2:0] move_direction,
    output logic       busy,
    output logic       clear_A,
    output logic       clear_B,
    output logic       clear_C,
    output logic       exit_done,
    output logic       reject
);

    localparam int              c_cw       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_cyc_last = c_cw'(STEP_CYCLES - 1);
    localparam logic [2:0]      c_a_dist   = 3'(A_DIST);
    localparam logic [2:0]      c_b_dist   = 3'(B_DIST);
    localparam logic [2:0]      c_c_dist   = 3'(C_DIST);

    localparam logic [2:0] c_dir_stop = 3'b000;
    localparam logic [2:0] c_dir_fwd  = 3'b001;
    localparam logic [2:0] c_dir_back = 3'b010;
    localparam logic [2:0] c_dir_grab = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_GRAB = 3'd2,
        S_BACK = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_cw-1:0] r_cyc;
    logic [2:0]      r_step;
    logic [2:0]      r_dist;
    logic [1:0]      r_place;

    logic            w_slot_full;
    logic [2:0]      w_req_dist;
    logic            w_cyc_last;
    logic            w_step_last;

    // Place 00 leaves w_slot_full low, so it is refused like an empty slot.
    always_comb begin
        w_slot_full = 1'b0;
        w_req_dist  = 3'd0;
        case (exit_place)
            2'b01: begin w_slot_full = A_full; w_req_dist = c_a_dist; end
            2'b10: begin w_slot_full = B_full; w_req_dist = c_b_dist; end
            2'b11: begin w_slot_full = C_full; w_req_dist = c_c_dist; end
            default: ;
        endcase
    end

    assign w_cyc_last  = (r_cyc == c_cyc_last);
    assign w_step_last = (r_step == r_dist - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cyc          <= '0;
            r_step         <= 3'd0;
            r_dist         <= 3'd0;
            r_place        <= 2'b00;
            move_direction <= c_dir_stop;
            busy           <= 1'b0;
            clear_A        <= 1'b0;
            clear_B        <= 1'b0;
            clear_C        <= 1'b0;
            exit_done      <= 1'b0;
            reject         <= 1'b0;
        end else begin
            clear_A   <= 1'b0;
            clear_B   <= 1'b0;
            clear_C   <= 1'b0;
            exit_done <= 1'b0;
            reject    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (exit_req) begin
                        if (w_slot_full) begin
                            r_state        <= S_FWD;
                            r_place        <= exit_place;
                            r_dist         <= w_req_dist;
                            r_cyc          <= '0;
                            r_step         <= 3'd0;
                            busy           <= 1'b1;
                            move_direction <= c_dir_fwd;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                S_FWD: begin
                    if (w_cyc_last) begin
                        r_cyc <= '0;
                        if (w_step_last) begin
                            r_step         <= 3'd0;
                            r_state        <= S_GRAB;
                            move_direction <= c_dir_grab;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_GRAB: begin
                    if (w_cyc_last) begin
                        r_cyc          <= '0;
                        r_state        <= S_BACK;
                        move_direction <= c_dir_back;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_BACK: begin
                    if (w_cyc_last) begin
                        r_cyc <= '0;
                        if (w_step_last) begin
                            r_step         <= 3'd0;
                            r_state        <= S_DONE;
                            move_direction <= c_dir_stop;
                            exit_done      <= 1'b1;
                            clear_A        <= (r_place == 2'b01);
                            clear_B        <= (r_place == 2'b10);
                            clear_C        <= (r_place == 2'b11);
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_DONE: begin
                    // Requests arriving here are only seen once back in IDLE.
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    busy           <= 1'b0;
                    move_direction <= c_dir_stop;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_car_exit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_car_exit
//  Purpose  : Directed self-checking bench for car_exit (STEP_CYCLES = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_car_exit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       exit_req = 1'b0;
    logic [1:0] exit_place = 2'b00;
    logic       A_full = 1'b0;
    logic       B_full = 1'b0;
    logic       C_full = 1'b0;
    logic [2:0] move_direction;
    logic       busy, clear_A, clear_B, clear_C, exit_done, reject;

    int n_tests = 0;
    int n_fail  = 0;

    car_exit #(.STEP_CYCLES(4), .A_DIST(1), .B_DIST(2), .C_DIST(3)) dut (
        .clk(clk), .rst(rst), .exit_req(exit_req), .exit_place(exit_place),
        .A_full(A_full), .B_full(B_full), .C_full(C_full),
        .move_direction(move_direction), .busy(busy),
        .clear_A(clear_A), .clear_B(clear_B), .clear_C(clear_C),
        .exit_done(exit_done), .reject(reject)
    );

    always #5 clk = ~clk;

    // {move_direction, busy, exit_done, clear_A, clear_B, clear_C, reject}
    logic [8:0] obs;
    assign obs = {move_direction, busy, exit_done, clear_A, clear_B, clear_C, reject};

    // Expected outputs in cycle k (1 = first cycle after acceptance) of a run
    function automatic logic [8:0] exp_vec(input int k, input int d, input logic [1:0] p);
        int         f;
        logic [2:0] dir;
        logic       fin;
        f   = d * 4;
        fin = (k == 2 * f + 5);
        if (k <= f)              dir = 3'b001;
        else if (k <= f + 4)     dir = 3'b100;
        else if (k <= 2 * f + 4) dir = 3'b010;
        else                     dir = 3'b000;
        return {dir, (k <= 2 * f + 5), fin, fin && (p == 2'b01),
                fin && (p == 2'b10), fin && (p == 2'b11), 1'b0};
    endfunction

    // Present a one-cycle request; returns at the sample point of cycle 1
    task automatic issue(input logic [1:0] p);
        @(negedge clk);
        exit_req   = 1'b1;
        exit_place = p;
        @(negedge clk);
        exit_req   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", obs, 9'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%b exp=%b", obs, 9'b0);
        end
    endtask

    task automatic test_exit_a();
        A_full = 1'b1;
        issue(2'b01);
        for (int k = 1; k <= 14; k++) begin
            n_tests++;
            if (obs !== exp_vec(k, 1, 2'b01)) begin
                n_fail++;
                $display("FAIL exit_a k=%0d got=%b exp=%b", k, obs, exp_vec(k, 1, 2'b01));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exit_c();
        C_full = 1'b1;
        issue(2'b11);
        for (int k = 1; k <= 30; k++) begin
            n_tests++;
            if (obs !== exp_vec(k, 3, 2'b11)) begin
                n_fail++;
                $display("FAIL exit_c k=%0d got=%b exp=%b", k, obs, exp_vec(k, 3, 2'b11));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reject();
        B_full = 1'b0;
        issue(2'b10);
        n_tests++;
        if (obs !== 9'b000_0_0_000_1) begin
            n_fail++;
            $display("FAIL reject_empty got=%b exp=%b", obs, 9'b000_0_0_000_1);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL reject_pulse_width got=%b exp=%b", obs, 9'b0);
        end
        A_full = 1'b1; B_full = 1'b1; C_full = 1'b1;
        issue(2'b00);
        n_tests++;
        if (obs !== 9'b000_0_0_000_1) begin
            n_fail++;
            $display("FAIL reject_place00 got=%b exp=%b", obs, 9'b000_0_0_000_1);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL reject00_pulse_width got=%b exp=%b", obs, 9'b0);
        end
    endtask

    task automatic test_ignore_busy();
        A_full = 1'b1; C_full = 1'b1;
        issue(2'b01);
        for (int k = 1; k <= 14; k++) begin
            n_tests++;
            if (obs !== exp_vec(k, 1, 2'b01)) begin
                n_fail++;
                $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, obs, exp_vec(k, 1, 2'b01));
            end
            if (k == 2) begin
                exit_req   = 1'b1;
                exit_place = 2'b11;
            end else begin
                exit_req = 1'b0;
            end
            @(negedge clk);
        end
        exit_req = 1'b0;
    endtask

    task automatic test_reset_abort();
        B_full = 1'b1;
        issue(2'b10);
        for (int k = 1; k <= 10; k++) begin
            n_tests++;
            if (obs !== exp_vec(k, 2, 2'b10)) begin
                n_fail++;
                $display("FAIL pre_abort k=%0d got=%b exp=%b", k, obs, exp_vec(k, 2, 2'b10));
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs !== 9'b0) begin
                n_fail++;
                $display("FAIL abort_idle k=%0d got=%b exp=%b", k, obs, 9'b0);
            end
            @(negedge clk);
        end
        issue(2'b10);
        for (int k = 1; k <= 22; k++) begin
            n_tests++;
            if (obs !== exp_vec(k, 2, 2'b10)) begin
                n_fail++;
                $display("FAIL exit_b_after_abort k=%0d got=%b exp=%b", k, obs, exp_vec(k, 2, 2'b10));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_drop();
        A_full = 1'b1;
        issue(2'b01);
        for (int k = 1; k <= 14; k++) begin
            n_tests++;
            if (obs !== exp_vec(k, 1, 2'b01)) begin
                n_fail++;
                $display("FAIL full_drop k=%0d got=%b exp=%b", k, obs, exp_vec(k, 1, 2'b01));
            end
            if (k == 10) A_full = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_exit_a();
        test_exit_c();
        test_reject();
        test_ignore_busy();
        test_reset_abort();
        test_full_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
